// File: rtl/bitwise_decode_reader_pkg.sv
// rtl/bitwise_decode_reader_pkg.sv - shared state encoding, op codes and op helper for the decode reader
package bitwise_decode_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        OUT   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Only XOR can be undone; every other write-side op destroys information.
    function automatic logic op_is_lossy(input logic [1:0] op);
        return op != OP_XOR;
    endfunction

endpackage

// File: rtl/bitwise_decode_reader_if.sv
// rtl/bitwise_decode_reader_if.sv - command, memory and stream signals of the decode reader (checksum port under CHECKSUM_EN)
interface bitwise_decode_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic [ADDR_W:0]   count;
    logic [1:0]        operation;
    logic              memMode;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] romData;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              dataReady;
    logic              lossy;
    logic              busy;
    logic              done;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
        output start, startAddr, count, operation, memData, romData, dataReady,
        input  memMode, memAddr, dataOut, dataValid, lossy, busy, done
`ifdef CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, startAddr, count, operation, memData, romData, dataReady,
        output memMode, memAddr, dataOut, dataValid, lossy, busy, done
`ifdef CHECKSUM_EN
        , output checksum
`endif
    );

endinterface

// File: rtl/bitwise_decode_reader_unit.sv
// rtl/bitwise_decode_reader_unit.sv - combinational inverse of the write-side bitwise op
module bitwise_decode_unit
    import bitwise_decode_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] word,
    output logic              lossy
);

    // XOR is self-inverse against the same ROM word; other ops pass the stored word raw.
    always_comb begin
        lossy = op_is_lossy(op);
        word  = lossy ? mem_data : (mem_data ^ rom_data);
    end

endmodule

// File: rtl/bitwise_decode_reader.sv
// rtl/bitwise_decode_reader.sv - sweeps RAM in read mode, decodes against ROM, streams words out (optional CHECKSUM_EN)
module bitwise_decode_reader
    import bitwise_decode_reader_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic CLK,
    input  logic RST_N,
    bitwise_decode_reader_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_SWEEP = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W:0]   remaining;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              lossy_r;
    logic              mem_mode;
    logic              busy;
    logic              done;
    logic [1:0]        dec_op;
    logic [DATA_W-1:0] dec_word;
    logic              dec_lossy;
    logic              xfer;

    assign xfer = data_valid && bus.dataReady;

    // In IDLE the unit looks at the incoming op so lossy can be latched at start.
    assign dec_op = (state == IDLE) ? bus.operation : op_r;

    bitwise_decode_unit #(.DATA_W(DATA_W)) u_decode (
        .op       (dec_op),
        .mem_data (bus.memData),
        .rom_data (bus.romData),
        .word     (dec_word),
        .lossy    (dec_lossy)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one fetch per word, leave after the last accepted word.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = OUT;
            OUT:     if (xfer) state_nxt = (remaining == 1) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        mem_mode = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            FETCH, OUT: begin
                mem_mode = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Sweep counters and output register; dataOut only changes on a fetch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_addr   <= '0;
            remaining  <= '0;
            op_r       <= 2'b00;
            data_out   <= '0;
            data_valid <= 1'b0;
            lossy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mem_addr  <= bus.startAddr;
                        op_r      <= bus.operation;
                        lossy_r   <= dec_lossy;
                        remaining <= (bus.count == '0) ? FULL_SWEEP : bus.count;
                    end
                end
                FETCH: begin
                    data_out   <= dec_word;
                    data_valid <= 1'b1;
                end
                OUT: begin
                    if (xfer) begin
                        data_valid <= 1'b0;
                        if (remaining != 1) begin
                            remaining <= remaining - 1'b1;
                            mem_addr  <= mem_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Running XOR of accepted words, cleared when a sweep is accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            checksum_r <= '0;
        end else if (state == IDLE && bus.start) begin
            checksum_r <= '0;
        end else if (state == OUT && xfer) begin
            checksum_r <= checksum_r ^ data_out;
        end
    end

    assign bus.checksum = checksum_r;
`endif

    assign bus.memMode   = mem_mode;
    assign bus.memAddr   = mem_addr;
    assign bus.dataOut   = data_out;
    assign bus.dataValid = data_valid;
    assign bus.lossy     = lossy_r;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_bitwise_decode_reader.sv
// tb/tb_bitwise_decode_reader.sv - scoreboard bench for bitwise_decode_reader with RAM/ROM models
module tb_bitwise_decode_reader;

    typedef struct {
        int addr;
        int data;
        int lossy;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic [7:0] ram [8];
    logic [7:0] rom [8];
    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int done_seen = 0;
    int exp_ck = 0;

    bitwise_decode_reader_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    bitwise_decode_reader #(.ADDR_W(3), .DATA_W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    assign bus.memData = ram[bus.memAddr];
    assign bus.romData = rom[bus.memAddr];

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected words of a sweep, straight from the address/decode rules.
    task automatic push_sweep(input int sa, input int cnt, input int op);
        int n;
        int a;
        int d;
        n = (cnt == 0) ? 8 : cnt;
        exp_ck = 0;
        for (int i = 0; i < n; i++) begin
            a = (sa + i) % 8;
            d = (op == 2) ? int'(ram[a] ^ rom[a]) : int'(ram[a]);
            exp_q.push_back('{addr: a, data: d, lossy: (op != 2) ? 1 : 0});
            exp_ck = exp_ck ^ d;
        end
    endtask

    task automatic run_sweep(input int sa, input int cnt, input int op, input int rmode, input int mid_start);
        int fin;
        int stalls;
        push_sweep(sa, cnt, op);
        exp_done++;
        bus.startAddr = 3'(sa);
        bus.count     = 4'(cnt);
        bus.operation = 2'(op);
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        fin = 0;
        stalls = 0;
        for (int c = 0; c < 200 && fin == 0; c++) begin
            case (rmode)
                0: bus.dataReady = 1'b1;
                1: bus.dataReady = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.dataValid && bus.memAddr == 3'd7 && stalls < 3) begin
                        bus.dataReady = 1'b0;
                        stalls++;
                    end else begin
                        bus.dataReady = 1'b1;
                    end
                end
            endcase
            bus.start = (mid_start != 0 && c == 3) ? 1'b1 : 1'b0;
            step();
            if (bus.done) fin = 1;
        end
        bus.start = 1'b0;
        check("sweep_finished", 32'(fin), 32'd1);
        check("done_busy_low", {31'd0, bus.busy}, 32'd0);
        step();
        check("idle_done_low", {31'd0, bus.done}, 32'd0);
        check("idle_memmode_low", {31'd0, bus.memMode}, 32'd0);
    endtask

    // Single XOR word at address 3 with exact cycle-by-cycle timing.
    task automatic single_word_test();
        ram[3] = 8'h79;
        exp_q.push_back('{addr: 3, data: 32'h5A, lossy: 0});
        exp_ck = 32'h5A;
        exp_done++;
        bus.startAddr = 3'd3;
        bus.count     = 4'd1;
        bus.operation = 2'b10;
        bus.dataReady = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        check("t1_valid_after_1", {31'd0, bus.dataValid}, 32'd0);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        check("t1_memmode", {31'd0, bus.memMode}, 32'd1);
        check("t1_memaddr", {29'd0, bus.memAddr}, 32'd3);
        step();
        check("t1_valid_after_2", {31'd0, bus.dataValid}, 32'd1);
        check("t1_dataout", {24'd0, bus.dataOut}, 32'h5A);
        check("t1_lossy", {31'd0, bus.lossy}, 32'd0);
        step();
        check("t1_done", {31'd0, bus.done}, 32'd1);
        check("t1_busy_done", {31'd0, bus.busy}, 32'd0);
        step();
        check("t1_done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability and done.
    initial begin
        logic stall_prev;
        logic [7:0] prev_data;
        exp_t e;
        stall_prev = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST_N !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", {31'd0, bus.dataValid}, 32'd1);
                    check("stall_data_held", {24'd0, bus.dataOut}, {24'd0, prev_data});
                end
                if (bus.dataValid && bus.dataReady) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_addr", {29'd0, bus.memAddr}, 32'(e.addr));
                        check("word_data", {24'd0, bus.dataOut}, 32'(e.data));
                        check("word_lossy", {31'd0, bus.lossy}, 32'(e.lossy));
                    end
                end
                stall_prev = bus.dataValid && !bus.dataReady;
                prev_data = bus.dataOut;
                if (bus.done) begin
                    done_seen++;
                    check("done_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef CHECKSUM_EN
                    check("done_checksum", {24'd0, bus.checksum}, 32'(exp_ck));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin;
        rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h04; rom[3] = 8'h23;
        rom[4] = 8'h10; rom[5] = 8'h20; rom[6] = 8'h40; rom[7] = 8'hD4;
        for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
        RST_N = 1'b0;
        bus.start = 1'b0;
        bus.startAddr = 3'd0;
        bus.count = 4'd0;
        bus.operation = 2'b00;
        bus.dataReady = 1'b0;
        #3;
        check("rst_memmode", {31'd0, bus.memMode}, 32'd0);
        check("rst_memaddr", {29'd0, bus.memAddr}, 32'd0);
        check("rst_dataout", {24'd0, bus.dataOut}, 32'd0);
        check("rst_valid", {31'd0, bus.dataValid}, 32'd0);
        check("rst_lossy", {31'd0, bus.lossy}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef CHECKSUM_EN
        check("rst_checksum", {24'd0, bus.checksum}, 32'd0);
`endif
        step();
        step();
        RST_N = 1'b1;
        step();

        single_word_test();

        // Full sweep with count 0.
        for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
        run_sweep(0, 0, 2, 0, 0);

        // Wrap from 6 with a 3-cycle stall on address 7.
        for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
        run_sweep(6, 4, 2, 2, 0);

        // Lossy AND sweep with an ignored start pulse mid-sweep.
        ram[4] = 8'hC4;
        run_sweep(4, 3, 0, 0, 1);

        // Reset while word 2 waits in OUT.
        push_sweep(0, 4, 2);
        bus.startAddr = 3'd0;
        bus.count = 4'd4;
        bus.operation = 2'b10;
        bus.dataReady = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 20 && !bus.dataValid; c++) step();
        check("rst_test_word1_valid", {31'd0, bus.dataValid}, 32'd1);
        bus.dataReady = 1'b1;
        step();
        bus.dataReady = 1'b0;
        for (int c = 0; c < 20 && !bus.dataValid; c++) step();
        check("rst_test_word2_valid", {31'd0, bus.dataValid}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("midrst_memmode", {31'd0, bus.memMode}, 32'd0);
        check("midrst_memaddr", {29'd0, bus.memAddr}, 32'd0);
        check("midrst_dataout", {24'd0, bus.dataOut}, 32'd0);
        check("midrst_valid", {31'd0, bus.dataValid}, 32'd0);
        check("midrst_lossy", {31'd0, bus.lossy}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        exp_q.delete();
        step();
        RST_N = 1'b1;
        step();
        single_word_test();

        // Randomized sweeps with random backpressure.
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
            run_sweep(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)), 1, 0);
        end

`ifdef CHECKSUM_EN
        for (int i = 0; i < 8; i++) ram[i] = 8'h00;
        run_sweep(0, 0, 2, 0, 0);
        check("checksum_rom_xor", {24'd0, bus.checksum}, 32'h80);
`endif

        step();
        step();
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        fin = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
